// File: rtl/shiftreg_cfg_sequencer_if.sv
// Parallel-word / serial-chain bundle between the config register bank and the
// shift-register sequencer. The bank side is master, the sequencer is slave.
interface shiftreg_cfg_sequencer_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
);
    logic                  start;
    logic                  continuous;
    logic                  stat_reload;
    logic [SIZESRSTAT-1:0] stat_word;
    logic [SIZESRDYN-1:0]  dyn_word;

    logic                  sdata;
    logic                  sel_stat;
    logic                  sel_dyn;
    logic                  latch;
    logic                  en_fin;
    logic                  stat_valid;
    logic                  busy;

    modport master (
        output start, continuous, stat_reload, stat_word, dyn_word,
        input  sdata, sel_stat, sel_dyn, latch, en_fin, stat_valid, busy
    );

    modport slave (
        input  start, continuous, stat_reload, stat_word, dyn_word,
        output sdata, sel_stat, sel_dyn, latch, en_fin, stat_valid, busy
    );
endinterface

// File: rtl/shiftreg_cfg_sequencer.sv
// Serial loader for the static and dynamic configuration shift registers:
// shifts each captured word MSB first, strobes latch after each, optionally loops.
module shiftreg_cfg_sequencer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int N_WAIT1    = 8,
    parameter int N_WAIT2    = 128,
    parameter int CNT_W      = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    shiftreg_cfg_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_1,
        S_SH_STAT,
        S_STAT_LATCH,
        S_SH_DYN,
        S_DYN_LATCH,
        S_WAIT_2
    } state_t;

    // Terminal count of each timed state: a state lasting N cycles exits at N-1.
    localparam logic [CNT_W-1:0] LAST_W1   = CNT_W'(N_WAIT1 - 1);
    localparam logic [CNT_W-1:0] LAST_STAT = CNT_W'(SIZESRSTAT - 1);
    localparam logic [CNT_W-1:0] LAST_DYN  = CNT_W'(SIZESRDYN - 1);
    localparam logic [CNT_W-1:0] LAST_W2   = CNT_W'(N_WAIT2 - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [SIZESRSTAT-1:0] stat_sh;
    logic [SIZESRSTAT-1:0] stat_sh_nxt;
    logic [SIZESRDYN-1:0]  dyn_sh;
    logic [SIZESRDYN-1:0]  dyn_sh_nxt;
    logic                  reload_pend;
    logic                  reload_pend_nxt;
    logic                  stat_valid_q;
    logic                  stat_valid_nxt;
    logic                  timed;
    logic                  enter_sh_stat;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            cnt          <= '0;
            stat_sh      <= '0;
            dyn_sh       <= '0;
            reload_pend  <= 1'b0;
            stat_valid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stat_sh      <= stat_sh_nxt;
            dyn_sh       <= dyn_sh_nxt;
            reload_pend  <= reload_pend_nxt;
            stat_valid_q <= stat_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        stat_sh_nxt    = stat_sh;
        dyn_sh_nxt     = dyn_sh;
        stat_valid_nxt = stat_valid_q;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    stat_sh_nxt = bus.stat_word;
                    dyn_sh_nxt  = bus.dyn_word;
                    state_nxt   = S_WAIT_1;
                end
            end

            // The static chain is only reshifted when it has never been latched
            // since reset, or when a reload has been requested.
            S_WAIT_1: begin
                if (cnt == LAST_W1) begin
                    if (!stat_valid_q || reload_pend) begin
                        state_nxt = S_SH_STAT;
                    end else begin
                        state_nxt = S_SH_DYN;
                    end
                end
            end

            S_SH_STAT: begin
                stat_sh_nxt = stat_sh << 1;
                if (cnt == LAST_STAT) begin
                    state_nxt = S_STAT_LATCH;
                end
            end

            S_STAT_LATCH: begin
                stat_valid_nxt = 1'b1;
                state_nxt      = S_SH_DYN;
            end

            S_SH_DYN: begin
                dyn_sh_nxt = dyn_sh << 1;
                if (cnt == LAST_DYN) begin
                    state_nxt = S_DYN_LATCH;
                end
            end

            S_DYN_LATCH: begin
                state_nxt = S_WAIT_2;
            end

            // Continuous mode skips IDLE and WAIT_1 and recaptures the words here.
            S_WAIT_2: begin
                if (cnt == LAST_W2) begin
                    if (bus.continuous) begin
                        dyn_sh_nxt = bus.dyn_word;
                        if (reload_pend) begin
                            stat_sh_nxt = bus.stat_word;
                            state_nxt   = S_SH_STAT;
                        end else begin
                            state_nxt   = S_SH_DYN;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        timed = (state == S_WAIT_1) || (state == S_SH_STAT) ||
                (state == S_SH_DYN) || (state == S_WAIT_2);
        if ((state_nxt != state) || !timed) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // A reload request arriving in the same cycle as SH_STAT entry must survive.
    always_comb begin
        enter_sh_stat   = (state_nxt == S_SH_STAT) && (state != S_SH_STAT);
        reload_pend_nxt = reload_pend;
        if (bus.stat_reload) begin
            reload_pend_nxt = 1'b1;
        end else if (enter_sh_stat) begin
            reload_pend_nxt = 1'b0;
        end
    end

    assign bus.sdata      = (state == S_SH_STAT) ? stat_sh[SIZESRSTAT-1] :
                            (state == S_SH_DYN)  ? dyn_sh[SIZESRDYN-1]   : 1'b0;
    assign bus.sel_stat   = (state == S_SH_STAT);
    assign bus.sel_dyn    = (state == S_SH_DYN);
    assign bus.latch      = (state == S_STAT_LATCH) || (state == S_DYN_LATCH);
    assign bus.en_fin     = (state == S_WAIT_2);
    assign bus.stat_valid = stat_valid_q;
    assign bus.busy       = (state != S_IDLE);

    a_sel_exclusive: assert property (@(posedge CLK) disable iff (!RST_N)
        !(bus.sel_stat && bus.sel_dyn));

    a_latch_single: assert property (@(posedge CLK) disable iff (!RST_N)
        bus.latch |=> !bus.latch);

endmodule

// File: tb/tb_shiftreg_cfg_sequencer.sv
// Randomised scoreboard bench for shiftreg_cfg_sequencer: a pass-level model
// predicts latched words and busy/idle run lengths; a monitor checks them.
module tb_shiftreg_cfg_sequencer;
    localparam int SS    = 88;
    localparam int SD    = 16;
    localparam int N1    = 8;
    localparam int N2    = 128;
    localparam int CW    = 8;
    localparam int ACC_W = 128;

    typedef struct {
        bit                 is_stat;
        logic [ACC_W-1:0]   word;
        int                 nbits;
    } latch_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    shiftreg_cfg_sequencer_if #(.SIZESRSTAT(SS), .SIZESRDYN(SD)) bus ();

    shiftreg_cfg_sequencer #(
        .SIZESRSTAT(SS),
        .SIZESRDYN (SD),
        .N_WAIT1   (N1),
        .N_WAIT2   (N2),
        .CNT_W     (CW)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    latch_t exp_latch[$];
    int     exp_busy[$];
    int     exp_gap[$];

    bit m_valid = 1'b0;
    bit m_pend  = 1'b0;

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pass-level model: decides whether the static word goes out, queues the
    // latched words in order and returns the number of busy cycles of the pass.
    task automatic plan_pass(input bit from_idle, input logic [SS-1:0] sw,
                             input logic [SD-1:0] dw, output int len, output int npush);
        latch_t e;
        bit inc;
        inc   = !m_valid || m_pend;
        len   = (from_idle ? N1 : 0) + SD + 1 + N2;
        npush = 1;
        if (inc) begin
            e.is_stat = 1'b1;
            e.word    = ACC_W'(sw);
            e.nbits   = SS;
            exp_latch.push_back(e);
            len     += SS + 1;
            npush    = 2;
            m_pend   = 1'b0;
            m_valid  = 1'b1;
        end
        e.is_stat = 1'b0;
        e.word    = ACC_W'(dw);
        e.nbits   = SD;
        exp_latch.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge CLK);
        while (bus.busy !== 1'b0 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        check("idle_within_bound", bus.busy, 1'b0);
    endtask

    // Issues a start from IDLE; returns at 1ns after the capturing edge.
    task automatic start_pass(input logic [SS-1:0] sw, input logic [SD-1:0] dw,
                              input bit push_busy, output int len, output int npush);
        plan_pass(1'b1, sw, dw, len, npush);
        exp_gap.push_back(-1);
        if (push_busy) exp_busy.push_back(len);
        bus.stat_word = sw;
        bus.dyn_word  = dw;
        bus.start     = 1'b1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    function automatic logic [SS-1:0] rand_stat();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[SS-1:0];
    endfunction

    // Monitor: rebuilds each shifted word and checks it at the latch strobe,
    // and measures busy runs, idle gaps and en_fin runs.
    initial begin : monitor
        logic [ACC_W-1:0] acc;
        latch_t e;
        int nb, busy_run, idle_run, en_run, eg;
        bit kind_stat, prev_busy;
        acc = '0; nb = 0; busy_run = 0; idle_run = 0; en_run = 0;
        kind_stat = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.sel_stat === 1'b1 && bus.sel_dyn === 1'b1) begin
                check("sel_exclusive", 1, 0);
            end
            if (bus.sel_stat !== 1'b1 && bus.sel_dyn !== 1'b1) begin
                check("sdata_quiet", bus.sdata, 1'b0);
            end else begin
                acc       = {acc[ACC_W-2:0], bus.sdata};
                nb++;
                kind_stat = (bus.sel_stat === 1'b1);
            end
            if (bus.latch === 1'b1) begin
                if (exp_latch.size() == 0) begin
                    check("latch_expected", 1, 0);
                end else begin
                    e = exp_latch.pop_front();
                    check("latch_kind", kind_stat, e.is_stat);
                    check("latch_bits", nb, e.nbits);
                    check("latch_word", acc, e.word);
                end
                acc = '0;
                nb  = 0;
            end
            if (bus.en_fin === 1'b1) begin
                en_run++;
            end else if (en_run > 0) begin
                check("en_fin_len", en_run, N2);
                en_run = 0;
            end
            if (bus.busy === 1'b1) begin
                if (!prev_busy) begin
                    if (exp_gap.size() == 0) begin
                        check("busy_rise_expected", 1, 0);
                    end else begin
                        eg = exp_gap.pop_front();
                        if (eg >= 0) check("idle_gap", idle_run, eg);
                    end
                end
                busy_run++;
                idle_run  = 0;
                prev_busy = 1'b1;
            end else begin
                if (prev_busy) begin
                    if (exp_busy.size() == 0) begin
                        check("busy_fall_expected", 1, 0);
                    end else begin
                        check("busy_len", busy_run, exp_busy.pop_front());
                    end
                end
                acc       = '0;
                nb        = 0;
                busy_run  = 0;
                idle_run++;
                prev_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [SS-1:0] sw;
        logic [SD-1:0] w [3];
        int len, np, acc_len;

        RST_N           = 1'b0;
        bus.start       = 1'b0;
        bus.continuous  = 1'b0;
        bus.stat_reload = 1'b0;
        bus.stat_word   = '0;
        bus.dyn_word    = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_sdata",      bus.sdata,      1'b0);
        check("rst_sel_stat",   bus.sel_stat,   1'b0);
        check("rst_sel_dyn",    bus.sel_dyn,    1'b0);
        check("rst_latch",      bus.latch,      1'b0);
        check("rst_en_fin",     bus.en_fin,     1'b0);
        check("rst_stat_valid", bus.stat_valid, 1'b0);
        check("rst_busy",       bus.busy,       1'b0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_idle();

        // First pass: full static load of a 1..0..1 pattern.
        sw = '0;
        sw[SS-1] = 1'b1;
        sw[0]    = 1'b1;
        start_pass(sw, 16'h8001, 1'b1, len, np);
        wait_idle();
        check("stat_valid_after_first", bus.stat_valid, 1'b1);

        // Second pass: static register already valid, so only the dynamic word.
        start_pass(rand_stat(), 16'hA5A5, 1'b1, len, np);
        wait_idle();

        // Random passes, some with a reload requested while idle.
        for (int r = 0; r < 3; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.stat_reload = 1'b1;
                m_pend = 1'b1;
                @(posedge CLK);
                #1;
                bus.stat_reload = 1'b0;
            end
            start_pass(rand_stat(), 16'($urandom), 1'b1, len, np);
            wait_idle();
            check("stat_valid_random", bus.stat_valid, m_valid);
        end

        // Continuous chain: word change in WAIT_2, then reload during SH_DYN.
        bus.continuous = 1'b1;
        start_pass(rand_stat(), 16'($urandom), 1'b0, len, np);
        acc_len = len;
        cycles(len - 10);
        bus.dyn_word = 16'h1234;
        plan_pass(1'b0, bus.stat_word, 16'h1234, len, np);
        acc_len += len;
        cycles(10);
        bus.stat_reload = 1'b1;
        m_pend          = 1'b1;
        bus.stat_word   = rand_stat();
        bus.dyn_word    = 16'($urandom);
        plan_pass(1'b0, bus.stat_word, bus.dyn_word, len, np);
        cycles(1);
        bus.stat_reload = 1'b0;
        cycles((acc_len - (N1 + SD + 1 + N2)) + len - 1 - 10);
        acc_len += len;
        bus.continuous = 1'b0;
        exp_busy.push_back(acc_len);
        wait_idle();
        check("stat_valid_continuous", bus.stat_valid, 1'b1);

        // Reset in the 40th SH_STAT cycle aborts the pass with no latch.
        bus.stat_reload = 1'b1;
        m_pend = 1'b1;
        @(posedge CLK);
        #1;
        bus.stat_reload = 1'b0;
        start_pass(rand_stat(), 16'($urandom), 1'b0, len, np);
        cycles(N1 + 39);
        RST_N = 1'b0;
        for (int i = 0; i < np; i++) void'(exp_latch.pop_back());
        exp_busy.push_back(N1 + 40);
        m_valid = 1'b0;
        m_pend  = 1'b0;
        cycles(1);
        RST_N = 1'b1;
        @(negedge CLK);
        check("abort_sdata",      bus.sdata,      1'b0);
        check("abort_sel_stat",   bus.sel_stat,   1'b0);
        check("abort_sel_dyn",    bus.sel_dyn,    1'b0);
        check("abort_latch",      bus.latch,      1'b0);
        check("abort_en_fin",     bus.en_fin,     1'b0);
        check("abort_stat_valid", bus.stat_valid, 1'b0);
        check("abort_busy",       bus.busy,       1'b0);
        start_pass(rand_stat(), 16'($urandom), 1'b1, len, np);
        wait_idle();
        check("stat_valid_after_abort", bus.stat_valid, 1'b1);

        // start held high: back-to-back passes with one IDLE cycle between.
        for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
        plan_pass(1'b1, bus.stat_word, w[0], len, np);
        exp_busy.push_back(len);
        exp_gap.push_back(-1);
        bus.dyn_word = w[0];
        bus.start    = 1'b1;
        @(posedge CLK);
        #1;
        for (int p = 1; p < 3; p++) begin
            cycles(50);
            bus.dyn_word = w[p];
            plan_pass(1'b1, bus.stat_word, w[p], len, np);
            exp_busy.push_back(len);
            exp_gap.push_back(1);
            cycles(104);
        end
        cycles(2);
        bus.start = 1'b0;
        wait_idle();

        cycles(5);
        check("latch_queue_drained", exp_latch.size(), 0);
        check("busy_queue_drained",  exp_busy.size(),  0);
        check("gap_queue_drained",   exp_gap.size(),   0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shiftreg_cfg_sequencer.md
Name: shiftreg_cfg_sequencer

Overview:
- Parametrised successor to the dynamic-register select FSM.
- Serially loads a static configuration shift register and a dynamic shift register from parallel words, MSB first, with a latch strobe after each.
- Static load happens once per power-up or on request; the dynamic load repeats in single-shot or continuous mode.
- Sits between the configuration register bank and the off-chip/ASIC shift-register chain.

Parameters:
- SIZESRSTAT, 88, static shift register length in bits (>=1)
- SIZESRDYN, 16, dynamic shift register length in bits (>=1)
- N_WAIT1, 8, cycles spent in WAIT_1 before shifting (>=1)
- N_WAIT2, 128, cycles spent in WAIT_2 after the dynamic latch (>=1)
- CNT_W, 8, state-cycle counter width; 2^CNT_W must exceed max(SIZESRSTAT, SIZESRDYN, N_WAIT1, N_WAIT2)

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST_N  in  1  reset, synchronous, active-low
- start  in  1  begin a load sequence; sampled only in IDLE
- continuous  in  1  1 = after WAIT_2, reload dynamic without returning to IDLE; sampled on the last WAIT_2 cycle
- stat_reload  in  1  request a static reload on the next pass; single-cycle pulse accepted
- stat_word  in  SIZESRSTAT  static configuration word
- dyn_word  in  SIZESRDYN  dynamic configuration word
- sdata  out  1  serial data to the chain
- sel_stat  out  1  static register shift enable
- sel_dyn  out  1  dynamic register shift enable
- latch  out  1  one-cycle latch strobe
- en_fin  out  1  dynamic word loaded; high throughout WAIT_2
- stat_valid  out  1  static register holds a latched word
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous: while RST_N=0 at an edge, the FSM goes to IDLE; all outputs are 0; counter, shadow registers and the reload flag are cleared; stat_valid is cleared. Reset mid-sequence aborts immediately, with no partial latch.
- Outputs are Moore-decoded from the state register plus the shadow MSB; no extra pipeline stage.
- States:
  - IDLE: On start=1, copy stat_word to stat_sh and dyn_word to dyn_sh, then go to WAIT_1.
  - WAIT_1: Stay exactly N_WAIT1 cycles. If stat_valid=0 or reload_pend=1, go to SH_STAT; otherwise go to SH_DYN.
  - SH_STAT: Stay exactly SIZESRSTAT cycles. sel_stat=1; sdata = stat_sh MSB; stat_sh shifts left with zero fill each cycle. reload_pend is cleared on entry. Then go to STAT_LATCH.
  - STAT_LATCH: 1 cycle. latch=1; stat_valid set at exit. Then go to SH_DYN.
  - SH_DYN: Stay exactly SIZESRDYN cycles. sel_dyn=1; sdata = dyn_sh MSB, shifting as above. Then go to DYN_LATCH.
  - DYN_LATCH: 1 cycle. latch=1. Then go to WAIT_2.
  - WAIT_2: Stay exactly N_WAIT2 cycles with en_fin=1. On exit:
    - continuous=1 and no pending reload: recapture dyn_word, go to SH_DYN.
    - continuous=1 and pending reload: recapture both words, go to SH_STAT.
    - continuous=0: go to IDLE.
- sdata=0, sel_*=0 and latch=0 in every state not listed for them.
- Counter:
  - Cleared on every state entry; increments each cycle in the timed states.
  - A state with N cycles exits when count == N-1.
  - No wrap-around is permitted; the CNT_W constraint guarantees this.
- reload_pend:
  - Set by stat_reload=1 in any state.
  - Cleared on SH_STAT entry.
  - If set and cleared in the same cycle, set wins.
- start while busy is ignored. Input words are only sampled at capture points, so changes mid-shift have no effect.
- Latency with defaults:
  - First pass from the start edge: 1 (IDLE) + 8 + 88 + 1 + 16 + 1 + 128; busy is high for 242 cycles.
  - Subsequent pass without reload: 8 + 16 + 1 + 128 = 153 busy cycles.

Test Plan:
- Reset, then start with stat_word = 88'h80…01, dyn_word = 16'h8001. Expect:
  - 8 WAIT_1 cycles, then sel_stat high for exactly 88 cycles, with sdata = 1, 0×86, 1.
  - latch pulse, then sel_dyn for 16 cycles, with sdata = 1, 0×14, 1.
  - latch pulse, then en_fin for 128 cycles, then idle; stat_valid=1.
- Second start with dyn_word = 16'hA5A5, no reload. Expect SH_STAT skipped, sel_stat never high, sdata = A5A5 MSB first, 153 busy cycles.
- continuous=1 with dyn_word changed during WAIT_2 to 16'h1234. Expect direct WAIT_2 -> SH_DYN, the new word shifted out, busy never drops.
- stat_reload pulsed during SH_DYN in continuous mode. Expect the next pass to include SH_STAT (88 cycles) before SH_DYN; reload_pend cleared.
- RST_N=0 for one edge in the 40th SH_STAT cycle. Expect next-cycle outputs all 0, no latch pulse, stat_valid=0; the following start performs a full static load.
- start held high continuously with continuous=0. Expect back-to-back passes, each separated by exactly one IDLE cycle; start pulses during busy produce no extra pass.
